bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Two-digit BCD seconds countdown timer that consumes the one-second tick produced by the seconds prescaler and drives the tens/ones digit outputs to the seven-segment decoders. It loads a start value, decrements once per tick while running, and issues a single-cycle timeout pulse when it reaches 00. It is the downstream end of the prescaler tick interface: the prescaler generates ticks, and this block counts them down into game-time digits.

## Interface
- START_TENS, default 4'd5: tens digit after reset (BCD, 0-9)
- START_ONES, default 4'd9: ones digit after reset (BCD, 0-9)
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- one_sec_in  in  1  one-second tick from the prescaler; single-cycle pulse
- load  in  1  level-sampled; latches tens_in/ones_in into the counter
- tens_in  in  4  BCD tens digit to load
- ones_in  in  4  BCD ones digit to load
- start  in  1  begins or resumes the countdown
- pause  in  1  suspends the countdown
- tens_out  out  4  current BCD tens digit
- ones_out  out  4  current BCD ones digit
- running  out  1  high while in RUN
- timeout  out  1  single-cycle pulse when the count reaches 00
- load_err  out  1  single-cycle pulse when a loaded digit is not valid BCD

## Operation
- FSM states are IDLE, RUN, PAUSED and EXPIRED. On reset the block enters IDLE with tens_out=START_TENS, ones_out=START_ONES, running=0, timeout=0, load_err=0.
- Input priority per cycle: reset, then load, then start, then pause, then one_sec_in.
- load is accepted in IDLE, PAUSED and EXPIRED. It latches the digits and moves to IDLE.
  - Any digit above 9 is clamped to 9, and load_err pulses on the same edge.
  - load is ignored in RUN.
- start in IDLE or PAUSED:
  - value nonzero: move to RUN.
  - value 00: move to EXPIRED and pulse timeout.
  - start is ignored in RUN and EXPIRED.
- pause in RUN moves to PAUSED. The digits hold, and a one_sec_in in the same cycle is dropped.
- one_sec_in in RUN decrements the count by 1 in BCD:
  - ones>0: ones-1.
  - ones=0: ones=9 and tens-1.
  - one_sec_in is ignored in every state other than RUN.
- When a decrement produces 00, the block moves to EXPIRED and pulses timeout. The digits hold at 00 until load or reset.
- Digit outputs never leave the range 0-9. There is no underflow below 00.

## Timing
- All outputs are registered and change on the rising clk edge that samples the causing input.
- Decrement latency is 1 cycle: the digits update on the edge that samples one_sec_in=1.
- timeout is high for exactly one cycle, on the same edge that the digits become 00 (or that start is sampled with the value at 00). It is not re-asserted while the block stays in EXPIRED.
- running rises on the edge that enters RUN and falls on the edge that leaves it.
- load_err is high for exactly one cycle, aligned with the load edge.
- Holding start high for several cycles is equivalent to a single start. Holding pause high keeps the block in PAUSED.
- reset asserted mid-count overrides everything. The next cycle shows the START values in IDLE, with no timeout pulse.
- Back-to-back one_sec_in on consecutive cycles each decrement, so 2 ticks subtract 2.

## Test plan
- Reset, then load 0x12, then start, then 12 ticks spaced 10 cycles apart:
  - digits step 12, 11, 10, 09 ... 01, 00.
  - running=1 throughout.
  - a single timeout pulse occurs on the 00 edge, then the block sits in EXPIRED with running=0.
- Borrow across tens: load 0x30, start, 1 tick -> digits read 29 on the next cycle.
- Pause collision: in RUN at 0x05, assert pause and one_sec_in in the same cycle -> digits stay 05 and the block is in PAUSED. A start then 5 ticks -> timeout, digits 00.
- Bad and zero load:
  - load tens_in=0xB, ones_in=0x3 -> digits 93, with a one-cycle load_err pulse.
  - load 0x00 followed by start -> immediate timeout pulse, EXPIRED, running never asserted.
- Ignored inputs:
  - load 0x44 while in RUN at 0x20 -> count unchanged.
  - ticks while in IDLE -> no change.
- Reset mid-operation: assert reset at count 0x17 in RUN -> next cycle reads START values 59 in IDLE, with running=0 and timeout=0.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer: loads a start value, decrements once per
// one-second tick while running, and pulses timeout when the count reaches 00.
module bcd_countdown_timer #(
  parameter logic [3:0] START_TENS = 4'd5,
  parameter logic [3:0] START_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec_in,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       running,
  output logic       timeout,
  output logic       load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state_reg, state_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic       timeout_reg, timeout_next;
  logic       load_err_reg, load_err_next;

  // Index 1 is the tens digit, index 0 the ones digit.
  logic [1:0][3:0] digit_in;
  logic [1:0][3:0] digit_clamped;
  logic [1:0]      digit_bad;

  assign digit_in = {tens_in, ones_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_clamp
      assign digit_bad[gi]     = (digit_in[gi] > 4'd9);
      assign digit_clamped[gi] = digit_bad[gi] ? 4'd9 : digit_in[gi];
    end
  endgenerate

  logic count_is_zero;
  assign count_is_zero = (tens_reg == 4'd0) && (ones_reg == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tens_reg     <= START_TENS;
      ones_reg     <= START_ONES;
      timeout_reg  <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tens_reg     <= tens_next;
      ones_reg     <= ones_next;
      timeout_reg  <= timeout_next;
      load_err_reg <= load_err_next;
    end
  end

  // Priority: load, then start, then pause, then tick. An input ignored in the
  // current state falls through to the next lower-priority one.
  always_comb begin
    state_next    = state_reg;
    tens_next     = tens_reg;
    ones_next     = ones_reg;
    timeout_next  = 1'b0;
    load_err_next = 1'b0;
    if (load && (state_reg != RUN)) begin
      state_next    = IDLE;
      tens_next     = digit_clamped[1];
      ones_next     = digit_clamped[0];
      load_err_next = |digit_bad;
    end else if (start && ((state_reg == IDLE) || (state_reg == PAUSED))) begin
      if (count_is_zero) begin
        state_next   = EXPIRED;
        timeout_next = 1'b1;
      end else begin
        state_next = RUN;
      end
    end else if (pause && (state_reg == RUN)) begin
      state_next = PAUSED;
    end else if (one_sec_in && (state_reg == RUN) && !count_is_zero) begin
      if (ones_reg != 4'd0) begin
        ones_next = ones_reg - 4'd1;
        if ((tens_reg == 4'd0) && (ones_reg == 4'd1)) begin
          state_next   = EXPIRED;
          timeout_next = 1'b1;
        end
      end else begin
        ones_next = 4'd9;
        tens_next = tens_reg - 4'd1;
      end
    end
  end

  always_comb begin
    tens_out = tens_reg;
    ones_out = ones_reg;
    running  = (state_reg == RUN);
    timeout  = timeout_reg;
    load_err = load_err_reg;
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a behavioural model pushes the
// expected outputs for every driven cycle; they are popped after the clock edge.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_sec_in = 1'b0;
  logic       load = 1'b0;
  logic [3:0] tens_in = 4'd0;
  logic [3:0] ones_in = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] tens_out, ones_out;
  logic       running, timeout, load_err;

  bcd_countdown_timer dut (
    .clk(clk), .reset(reset), .one_sec_in(one_sec_in), .load(load),
    .tens_in(tens_in), .ones_in(ones_in), .start(start), .pause(pause),
    .tens_out(tens_out), .ones_out(ones_out), .running(running),
    .timeout(timeout), .load_err(load_err)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int m_state = M_IDLE;
  int m_val   = 59;
  logic m_to = 1'b0;
  logic m_le = 1'b0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got t=%0h o=%0h run=%b to=%b le=%b want t=%0h o=%0h run=%b to=%b le=%b",
               tag, cycle, got[10:7], got[6:3], got[2], got[1], got[0],
               want[10:7], want[6:3], want[2], want[1], want[0]);
    end else begin
      $display("ok   %s cycle %0d: t=%0h o=%0h run=%b to=%b le=%b",
               tag, cycle, got[10:7], got[6:3], got[2], got[1], got[0]);
    end
  endtask

  // Model works on the integer value of the count rather than BCD digits.
  task automatic model(input logic rst, input logic ld, input logic [3:0] ti,
                       input logic [3:0] oi, input logic st, input logic pa,
                       input logic tk);
    int t, o;
    m_to = 1'b0;
    m_le = 1'b0;
    if (rst) begin
      m_state = M_IDLE;
      m_val   = 59;
    end else if (ld && m_state != M_RUN) begin
      t = (ti > 9) ? 9 : int'(ti);
      o = (oi > 9) ? 9 : int'(oi);
      m_le    = (ti > 9) || (oi > 9);
      m_val   = t * 10 + o;
      m_state = M_IDLE;
    end else if (st && (m_state == M_IDLE || m_state == M_PAUSED)) begin
      if (m_val == 0) begin
        m_state = M_EXPIRED;
        m_to    = 1'b1;
      end else begin
        m_state = M_RUN;
      end
    end else if (pa && m_state == M_RUN) begin
      m_state = M_PAUSED;
    end else if (tk && m_state == M_RUN) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_state = M_EXPIRED;
        m_to    = 1'b1;
      end
    end
  endtask

  task automatic drive(input string tag, input logic rst, input logic ld,
                       input logic [3:0] ti, input logic [3:0] oi,
                       input logic st, input logic pa, input logic tk);
    logic [10:0] want;
    logic [3:0] et, eo;
    reset = rst; load = ld; tens_in = ti; ones_in = oi;
    start = st; pause = pa; one_sec_in = tk;
    model(rst, ld, ti, oi, st, pa, tk);
    et = 4'(m_val / 10);
    eo = 4'(m_val % 10);
    exp_q.push_back({et, eo, (m_state == M_RUN), m_to, m_le});
    @(posedge clk);
    #1;
    cycle++;
    want = exp_q.pop_front();
    check(tag, {tens_out, ones_out, running, timeout, load_err}, want);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    drive("reset", 1, 0, 0, 0, 0, 0, 0);
    drive("reset", 1, 0, 0, 0, 0, 0, 0);
    idle("reset_idle", 1);

    // Full countdown from 12 with ticks every 10 cycles
    drive("load12", 0, 1, 4'd1, 4'd2, 0, 0, 0);
    drive("start12", 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tick("count12");
      idle("count12_gap", 9);
    end

    // Borrow across tens
    drive("load30", 0, 1, 4'd3, 4'd0, 0, 0, 0);
    drive("start30", 0, 0, 0, 0, 1, 0, 0);
    tick("borrow");
    idle("borrow_hold", 2);

    // Pause collides with tick, then resume to timeout
    drive("load05", 0, 1, 4'd0, 4'd5, 0, 0, 0);
    drive("start05", 0, 0, 0, 0, 1, 0, 0);
    drive("pause_tick", 0, 0, 0, 0, 0, 1, 1);
    drive("pause_hold", 0, 0, 0, 0, 0, 1, 1);
    idle("paused", 2);
    drive("resume", 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick("count05");
      idle("count05_gap", 1);
    end
    tick("expired_tick");

    // Bad digit clamps with load_err; zero load then start times out at once
    drive("load_bad", 0, 1, 4'hB, 4'h3, 0, 0, 0);
    idle("after_bad", 1);
    drive("load_both_bad", 0, 1, 4'hF, 4'hA, 0, 0, 0);
    drive("load00", 0, 1, 4'd0, 4'd0, 0, 0, 0);
    drive("start00", 0, 0, 0, 0, 1, 0, 0);
    drive("start00_hold", 0, 0, 0, 0, 1, 0, 0);
    idle("expired00", 2);

    // Load ignored in RUN; ticks ignored in IDLE
    drive("load20", 0, 1, 4'd2, 4'd0, 0, 0, 0);
    drive("start20", 0, 0, 0, 0, 1, 0, 0);
    drive("start20_hold", 0, 0, 0, 0, 1, 0, 0);
    drive("load44_run", 0, 1, 4'd4, 4'd4, 0, 0, 0);
    idle("run20", 1);
    drive("pause20", 0, 0, 0, 0, 0, 1, 0);
    drive("load33", 0, 1, 4'd3, 4'd3, 0, 0, 0);
    tick("idle_tick");
    tick("idle_tick");

    // Back-to-back ticks
    drive("load21", 0, 1, 4'd2, 4'd1, 0, 0, 0);
    drive("start21", 0, 0, 0, 0, 1, 0, 0);
    tick("b2b");
    tick("b2b");
    tick("b2b");

    // Reset mid-count at 17
    drive("load18", 0, 1, 4'd1, 4'd8, 0, 0, 0);
    drive("start18", 0, 0, 0, 0, 1, 0, 0);
    tick("to17");
    drive("reset_mid", 1, 0, 0, 0, 0, 0, 1);
    idle("after_reset", 2);

    // Random mix of all inputs against the model
    for (int k = 0; k < 400; k++) begin
      drive("random", ($urandom_range(0, 79) == 0), ($urandom_range(0, 11) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
